// File: rtl/mem_arbiter_if.sv
// Accessor and memory bundle for mem_arbiter; the arbiter takes the slave side,
// the accessors plus memory model take the master side.
interface mem_arbiter_if #(
   parameter int BITSIZE          = 32,
   parameter int N_WORDS_PER_ADDR = 4,
   parameter int N_ACCESSORS      = 2
);
   localparam int L = BITSIZE * N_WORDS_PER_ADDR;

   logic [32*N_ACCESSORS-1:0] acc_address_i;
   logic [N_ACCESSORS-1:0]    acc_store_i;
   logic [N_ACCESSORS-1:0]    acc_load_i;
   logic [L*N_ACCESSORS-1:0]  acc_wdata_i;
   logic [L-1:0]              acc_rdata_o;
   logic [N_ACCESSORS-1:0]    acc_ready_o;
   logic [N_ACCESSORS-1:0]    acc_done_o;
   logic [N_ACCESSORS-1:0]    acc_err_o;

   logic [31:0]               mem_addr_o;
   logic [L-1:0]              mem_wdata_o;
   logic                      mem_store_o;
   logic                      mem_valid_o;
   logic [L-1:0]              mem_rdata_i;
   logic                      mem_valid_i;

   modport slave (
      input  acc_address_i, acc_store_i, acc_load_i, acc_wdata_i,
      input  mem_rdata_i, mem_valid_i,
      output acc_rdata_o, acc_ready_o, acc_done_o, acc_err_o,
      output mem_addr_o, mem_wdata_o, mem_store_o, mem_valid_o
   );

   modport master (
      output acc_address_i, acc_store_i, acc_load_i, acc_wdata_i,
      output mem_rdata_i, mem_valid_i,
      input  acc_rdata_o, acc_ready_o, acc_done_o, acc_err_o,
      input  mem_addr_o, mem_wdata_o, mem_store_o, mem_valid_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port; request->mem_valid 1 cycle, done 1 cycle after response.
// One transaction in flight: acc_ready_o drops for BUSY/DONE and a silent memory is cut off after TIMEOUT cycles.
module mem_arbiter #(
   parameter int BITSIZE          = 32,
   parameter int N_WORDS_PER_ADDR = 4,
   parameter int N_ACCESSORS      = 2,
   parameter int TIMEOUT          = 255
) (
   input  logic         clk,
   input  logic         rst_i,
   mem_arbiter_if.slave bus
);
   localparam int          L   = BITSIZE * N_WORDS_PER_ADDR;
   localparam int          PW  = (N_ACCESSORS > 1) ? $clog2(N_ACCESSORS) : 1;
   localparam logic [15:0] TMO = 16'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [N_ACCESSORS-1:0] pending;
   logic [PW-1:0]          idx;
   logic [PW-1:0]          pick;
   logic                   pick_vld;

   logic [PW-1:0]          ptr;
   logic [PW-1:0]          grant;
   logic [15:0]            cnt;
   logic                   err_q;
   logic                   store_q;
   logic [31:0]            addr_q;
   logic [L-1:0]           wdata_q;
   logic [L-1:0]           rdata_q;
   logic [N_ACCESSORS-1:0] done_vec;

   assign pending = bus.acc_load_i | bus.acc_store_i;

   // Scan starts one past the last grant so the previous winner is checked last.
   always_comb begin
      idx      = '0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= N_ACCESSORS; k++) begin
         idx = PW'((int'(ptr) + k) % N_ACCESSORS);
         if (!pick_vld && pending[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pick_vld) state_nxt = BUSY;
         BUSY:    if (bus.mem_valid_i || cnt == TMO) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         ptr     <= PW'(N_ACCESSORS - 1);
         grant   <= '0;
         cnt     <= '0;
         err_q   <= 1'b0;
         store_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant   <= pick;
                  addr_q  <= bus.acc_address_i[32*int'(pick) +: 32];
                  wdata_q <= bus.acc_wdata_i[L*int'(pick) +: L];
                  store_q <= bus.acc_store_i[pick];
                  cnt     <= 16'd1;
                  err_q   <= 1'b0;
               end
            end
            BUSY: begin
               // A response on the final counted cycle still beats the timeout.
               if (bus.mem_valid_i) begin
                  if (!store_q) rdata_q <= bus.mem_rdata_i;
               end else if (cnt == TMO) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DONE: ptr <= grant;
            default: ;
         endcase
      end
   end

   always_comb begin
      done_vec = '0;
      if (state == DONE) done_vec[grant] = 1'b1;
   end

   assign bus.acc_ready_o = {N_ACCESSORS{state == IDLE}};
   assign bus.acc_done_o  = done_vec;
   assign bus.acc_err_o   = done_vec & {N_ACCESSORS{err_q}};
   assign bus.acc_rdata_o = rdata_q;

   assign bus.mem_valid_o = (state == BUSY);
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.mem_store_o = store_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios for mem_arbiter with a 1-cycle-or-silent memory and TIMEOUT=4.
module tb_mem_arbiter;
   localparam int BITSIZE = 32;
   localparam int NW      = 4;
   localparam int NA      = 2;
   localparam int TMO     = 4;
   localparam int L       = BITSIZE * NW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   localparam logic [L-1:0] DATA1 = 128'hDEADBEEF_00000000_00000000_00000001;
   localparam logic [L-1:0] DATA2 = 128'hCAFEF00D_12345678_9ABCDEF0_0F0F0F0F;
   localparam logic [L-1:0] ONES1 = 128'h11111111_11111111_11111111_11111111;

   mem_arbiter_if #(.BITSIZE(BITSIZE), .N_WORDS_PER_ADDR(NW), .N_ACCESSORS(NA)) bus ();

   mem_arbiter #(
      .BITSIZE(BITSIZE), .N_WORDS_PER_ADDR(NW), .N_ACCESSORS(NA), .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst_i(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.acc_address_i = '0;
      bus.acc_store_i   = '0;
      bus.acc_load_i    = '0;
      bus.acc_wdata_i   = '0;
      bus.mem_rdata_i   = '0;
      bus.mem_valid_i   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_total++; if (bus.acc_ready_o !== 2'b11) $display("FAIL reset_ready: got %b want 11", bus.acc_ready_o); else n_pass++;
      n_total++; if (bus.mem_valid_o !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", bus.mem_valid_o); else n_pass++;
      n_total++; if (bus.mem_store_o !== 1'b0 || bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== '0)
         $display("FAIL reset_mem_cmd: got st=%b a=%h w=%h want zeros", bus.mem_store_o, bus.mem_addr_o, bus.mem_wdata_o); else n_pass++;
      n_total++; if (bus.acc_done_o !== 2'b00 || bus.acc_err_o !== 2'b00 || bus.acc_rdata_o !== '0)
         $display("FAIL reset_acc_out: got d=%b e=%b r=%h want zeros", bus.acc_done_o, bus.acc_err_o, bus.acc_rdata_o); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_single_load();
      bus.acc_address_i[31:0] = 32'h40;
      bus.acc_load_i          = 2'b01;
      tick();
      n_total++; if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 32'h40 || bus.mem_store_o !== 1'b0)
         $display("FAIL load_cmd: got v=%b a=%h st=%b want v=1 a=40 st=0", bus.mem_valid_o, bus.mem_addr_o, bus.mem_store_o); else n_pass++;
      n_total++; if (bus.acc_ready_o !== 2'b00) $display("FAIL load_busy_ready: got %b want 00", bus.acc_ready_o); else n_pass++;
      bus.acc_load_i  = 2'b00;
      bus.mem_valid_i = 1'b1;
      bus.mem_rdata_i = DATA1;
      tick();
      bus.mem_valid_i = 1'b0;
      bus.mem_rdata_i = '0;
      n_total++; if (bus.acc_done_o !== 2'b01 || bus.acc_err_o !== 2'b00)
         $display("FAIL load_done: got d=%b e=%b want d=01 e=00", bus.acc_done_o, bus.acc_err_o); else n_pass++;
      n_total++; if (bus.acc_rdata_o !== DATA1) $display("FAIL load_rdata: got %h want %h", bus.acc_rdata_o, DATA1); else n_pass++;
      n_total++; if (bus.mem_valid_o !== 1'b0) $display("FAIL load_done_mem_valid: got %b want 0", bus.mem_valid_o); else n_pass++;
      tick();
      n_total++; if (bus.acc_done_o !== 2'b00 || bus.acc_ready_o !== 2'b11 || bus.acc_rdata_o !== DATA1)
         $display("FAIL load_back_idle: got d=%b rdy=%b r=%h", bus.acc_done_o, bus.acc_ready_o, bus.acc_rdata_o); else n_pass++;
   endtask

   task automatic test_contention();
      int          exp_g [4] = '{0, 1, 0, 1};
      logic [31:0] exp_a;
      logic [L-1:0] rd;
      logic [1:0]  exp_d;
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.acc_address_i = {32'h20, 32'h10};
      bus.acc_load_i    = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_a = (exp_g[k] == 0) ? 32'h10 : 32'h20;
         exp_d = (exp_g[k] == 0) ? 2'b01 : 2'b10;
         rd    = L'(32'hA000 + k);
         tick();
         n_total++; if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== exp_a)
            $display("FAIL cont_grant%0d: got v=%b a=%h want v=1 a=%h", k, bus.mem_valid_o, bus.mem_addr_o, exp_a); else n_pass++;
         bus.mem_valid_i = 1'b1;
         bus.mem_rdata_i = rd;
         tick();
         bus.mem_valid_i = 1'b0;
         n_total++; if (bus.acc_done_o !== exp_d || bus.acc_rdata_o !== rd)
            $display("FAIL cont_done%0d: got d=%b r=%h want d=%b r=%h", k, bus.acc_done_o, bus.acc_rdata_o, exp_d, rd); else n_pass++;
         tick();
         n_total++; if (bus.acc_ready_o !== 2'b11 || bus.acc_done_o !== 2'b00)
            $display("FAIL cont_idle%0d: got rdy=%b d=%b want 11 00", k, bus.acc_ready_o, bus.acc_done_o); else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_store();
      logic [L-1:0] prev;
      prev = L'(32'hA003);
      bus.acc_address_i = {32'h100, 32'h0};
      bus.acc_wdata_i   = {ONES1, {L{1'b1}}};
      bus.acc_store_i   = 2'b10;
      bus.acc_load_i    = 2'b10;
      tick();
      n_total++; if (bus.mem_store_o !== 1'b1 || bus.mem_addr_o !== 32'h100 || bus.mem_wdata_o !== ONES1)
         $display("FAIL store_cmd: got st=%b a=%h w=%h want st=1 a=100 w=%h", bus.mem_store_o, bus.mem_addr_o, bus.mem_wdata_o, ONES1); else n_pass++;
      clear_inputs();
      bus.mem_valid_i = 1'b1;
      bus.mem_rdata_i = {L{1'b1}};
      tick();
      bus.mem_valid_i = 1'b0;
      n_total++; if (bus.acc_done_o !== 2'b10 || bus.acc_err_o !== 2'b00)
         $display("FAIL store_done: got d=%b e=%b want d=10 e=00", bus.acc_done_o, bus.acc_err_o); else n_pass++;
      n_total++; if (bus.acc_rdata_o !== prev) $display("FAIL store_rdata_kept: got %h want %h", bus.acc_rdata_o, prev); else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_timeout();
      bus.acc_address_i[31:0] = 32'h80;
      bus.acc_load_i          = 2'b01;
      tick();
      bus.acc_load_i = 2'b00;
      for (int c = 1; c <= TMO; c++) begin
         n_total++; if (bus.mem_valid_o !== 1'b1 || bus.acc_done_o !== 2'b00)
            $display("FAIL tmo_wait%0d: got v=%b d=%b want v=1 d=00", c, bus.mem_valid_o, bus.acc_done_o); else n_pass++;
         tick();
      end
      n_total++; if (bus.acc_done_o !== 2'b01 || bus.acc_err_o !== 2'b01)
         $display("FAIL tmo_done: got d=%b e=%b want d=01 e=01", bus.acc_done_o, bus.acc_err_o); else n_pass++;
      n_total++; if (bus.acc_rdata_o !== '0) $display("FAIL tmo_rdata: got %h want 0", bus.acc_rdata_o); else n_pass++;
      tick();
      // Second transaction: response arrives on the last counted cycle.
      bus.acc_address_i[63:32] = 32'h84;
      bus.acc_load_i           = 2'b10;
      tick();
      bus.acc_load_i = 2'b00;
      tick();
      tick();
      tick();
      n_total++; if (bus.mem_valid_o !== 1'b1 || bus.acc_done_o !== 2'b00)
         $display("FAIL tmo_edge_wait: got v=%b d=%b want v=1 d=00", bus.mem_valid_o, bus.acc_done_o); else n_pass++;
      bus.mem_valid_i = 1'b1;
      bus.mem_rdata_i = DATA2;
      tick();
      bus.mem_valid_i = 1'b0;
      n_total++; if (bus.acc_done_o !== 2'b10 || bus.acc_err_o !== 2'b00 || bus.acc_rdata_o !== DATA2)
         $display("FAIL tmo_edge_done: got d=%b e=%b r=%h want d=10 e=00 r=%h", bus.acc_done_o, bus.acc_err_o, bus.acc_rdata_o, DATA2); else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset_mid_busy();
      bus.acc_address_i = {32'h200, 32'h300};
      bus.acc_load_i    = 2'b10;
      tick();
      n_total++; if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 32'h200)
         $display("FAIL rmb_busy: got v=%b a=%h want v=1 a=200", bus.mem_valid_o, bus.mem_addr_o); else n_pass++;
      bus.acc_load_i = 2'b00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++; if (bus.mem_valid_o !== 1'b0 || bus.mem_addr_o !== 32'h0 || bus.acc_rdata_o !== '0 || bus.acc_done_o !== 2'b00)
         $display("FAIL rmb_reset: got v=%b a=%h r=%h d=%b want zeros", bus.mem_valid_o, bus.mem_addr_o, bus.acc_rdata_o, bus.acc_done_o); else n_pass++;
      bus.mem_valid_i = 1'b1;
      bus.mem_rdata_i = DATA1;
      tick();
      bus.mem_valid_i = 1'b0;
      n_total++; if (bus.acc_done_o !== 2'b00 || bus.acc_err_o !== 2'b00 || bus.acc_ready_o !== 2'b11 || bus.acc_rdata_o !== '0)
         $display("FAIL rmb_late_resp: got d=%b e=%b rdy=%b r=%h", bus.acc_done_o, bus.acc_err_o, bus.acc_ready_o, bus.acc_rdata_o); else n_pass++;
      bus.acc_load_i = 2'b11;
      tick();
      n_total++; if (bus.mem_addr_o !== 32'h300) $display("FAIL rmb_next_grant: got a=%h want 300", bus.mem_addr_o); else n_pass++;
      bus.acc_load_i  = 2'b00;
      bus.mem_valid_i = 1'b1;
      bus.mem_rdata_i = DATA2;
      tick();
      bus.mem_valid_i = 1'b0;
      n_total++; if (bus.acc_done_o !== 2'b01 || bus.acc_rdata_o !== DATA2)
         $display("FAIL rmb_done: got d=%b r=%h want d=01 r=%h", bus.acc_done_o, bus.acc_rdata_o, DATA2); else n_pass++;
      tick();
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_load();
      test_contention();
      test_store();
      test_timeout();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
